// File: rtl/uart_tx_buffer.sv
// Word-to-byte serializer for the UART transmitter. It holds one active word and one pending word,
// and sends each word LSB first as one byte per UART frame.
module uart_tx_buffer #(
    parameter int WORD_BYTES = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [8*WORD_BYTES-1:0] tx_float,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic [7:0]              uart_byte,
    output logic                    uart_start,
    input  logic                    uart_busy,
    input  logic                    uart_done,
    output logic                    word_sent,
    output logic                    idle,
    output logic [1:0]              fsm_state_o
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_GAP       = 2'd3
    } state_t;

    localparam int            IW         = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IW-1:0] IDX_LAST   = IW'(WORD_BYTES - 1);
    localparam int            GW         = 16;
    localparam logic [GW-1:0] GAP_LAST   = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
    localparam state_t        AFTER_BYTE = (GAP_CYCLES > 0) ? S_GAP : S_START;

    state_t                  state_q, state_d;
    logic [8*WORD_BYTES-1:0] active_q, active_d;
    logic [8*WORD_BYTES-1:0] pending_q, pending_d;
    logic                    active_full_q, active_full_d;
    logic                    pending_full_q, pending_full_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [GW-1:0]           gap_q, gap_d;
    logic                    word_sent_q, word_sent_d;

    logic                    accept;
    logic                    last_done;
    logic [WORD_BYTES-1:0][7:0] active_bytes;

    // Handshake: a word transfers on a rising edge where tx_valid && tx_ready; tx_ready depends only
    // on the pending slot, never on tx_valid, and tx_float is sampled only on that edge.
    assign accept       = tx_valid && !pending_full_q;
    assign last_done    = (state_q == S_WAIT_DONE) && uart_done && (idx_q == IDX_LAST);
    assign active_bytes = active_q;

    assign tx_ready    = !pending_full_q;
    assign uart_byte   = active_bytes[idx_q];
    assign uart_start  = (state_q == S_START) && !uart_busy;
    assign word_sent   = word_sent_q;
    assign idle        = !active_full_q && !pending_full_q && (state_q == S_IDLE);
    assign fsm_state_o = state_q;

    always_comb begin
        state_d        = state_q;
        active_d       = active_q;
        pending_d      = pending_q;
        active_full_d  = active_full_q;
        pending_full_d = pending_full_q;
        idx_d          = idx_q;
        gap_d          = gap_q;
        word_sent_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (active_full_q) state_d = S_START;
            end
            S_START: begin
                if (!uart_busy) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (uart_done) begin
                    gap_d = '0;
                    if (idx_q != IDX_LAST) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = AFTER_BYTE;
                    end else begin
                        word_sent_d = 1'b1;
                        idx_d       = '0;
                        if (pending_full_q) begin
                            active_d       = pending_q;
                            pending_d      = '0;
                            pending_full_d = 1'b0;
                            state_d        = AFTER_BYTE;
                        end else if (accept) begin
                            active_d = tx_float;
                            state_d  = AFTER_BYTE;
                        end else begin
                            active_d      = '0;
                            active_full_d = 1'b0;
                            state_d       = S_IDLE;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = S_START;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A word arriving on the final uart_done with an empty pending slot was loaded above.
        if (accept && !(last_done && !pending_full_q)) begin
            if (!active_full_q) begin
                active_d      = tx_float;
                active_full_d = 1'b1;
                state_d       = S_START;
            end else begin
                pending_d      = tx_float;
                pending_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            active_q       <= '0;
            pending_q      <= '0;
            active_full_q  <= 1'b0;
            pending_full_q <= 1'b0;
            idx_q          <= '0;
            gap_q          <= '0;
            word_sent_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            active_full_q  <= active_full_d;
            pending_full_q <= pending_full_d;
            idx_q          <= idx_d;
            gap_q          <= gap_d;
            word_sent_q    <= word_sent_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: instance 0 has no inter-byte gap and instance 1 has a 3-cycle gap.
// Each instance is driven by an ideal UART model, and expected bytes are kept in per-instance queues.
module tb_uart_tx_buffer;

    localparam int FRAME = 4;
    localparam int GAP1  = 3;

    logic        clk;
    logic        reset;
    logic [31:0] tx_float   [2];
    logic        tx_valid   [2];
    logic        tx_ready   [2];
    logic [7:0]  uart_byte  [2];
    logic        uart_start [2];
    logic        uart_busy  [2];
    logic        uart_done  [2];
    logic        word_sent  [2];
    logic        idle       [2];
    logic [1:0]  fsm_state  [2];

    logic        m_busy [2];
    logic        m_done [2];
    int          m_cnt  [2];
    logic        start_seen [2];
    logic        hold_busy;
    logic        inj_done;

    logic [7:0]  exp_q0[$];
    logic [7:0]  exp_q1[$];
    int          st_cnt [2];
    int          ws_cnt [2];
    int          done_cyc [2];
    logic        done_pending [2];
    int          cyc;
    int          n_checks;
    int          n_fail;

    assign uart_busy[0] = m_busy[0] | hold_busy;
    assign uart_done[0] = m_done[0] | inj_done;
    assign uart_busy[1] = m_busy[1];
    assign uart_done[1] = m_done[1];

    uart_tx_buffer #(.WORD_BYTES(4), .GAP_CYCLES(0)) dut (
        .clk(clk), .reset(reset), .tx_float(tx_float[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .uart_byte(uart_byte[0]), .uart_start(uart_start[0]),
        .uart_busy(uart_busy[0]), .uart_done(uart_done[0]), .word_sent(word_sent[0]),
        .idle(idle[0]), .fsm_state_o(fsm_state[0])
    );

    uart_tx_buffer #(.WORD_BYTES(4), .GAP_CYCLES(GAP1)) dut_gap (
        .clk(clk), .reset(reset), .tx_float(tx_float[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .uart_byte(uart_byte[1]), .uart_start(uart_start[1]),
        .uart_busy(uart_busy[1]), .uart_done(uart_done[1]), .word_sent(word_sent[1]),
        .idle(idle[1]), .fsm_state_o(fsm_state[1])
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ideal UART core: it goes busy after a start, and after FRAME cycles it drops busy and pulses done.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            if (start_seen[i]) begin
                m_busy[i] = 1'b1;
                m_cnt[i]  = FRAME;
                m_done[i] = 1'b0;
            end else if (m_busy[i]) begin
                m_cnt[i]--;
                if (m_cnt[i] == 0) begin
                    m_busy[i] = 1'b0;
                    m_done[i] = 1'b1;
                end else begin
                    m_done[i] = 1'b0;
                end
            end else begin
                m_done[i] = 1'b0;
            end
        end
    end

    // Monitor and scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [7:0] e;
            logic       empty;
            start_seen[i] = uart_start[i];
            if (reset) begin
                done_pending[i] = 1'b0;
            end else begin
                if (uart_start[i]) begin
                    st_cnt[i]++;
                    if (done_pending[i]) begin
                        check($sformatf("done_to_start_%0d", i), 32'(cyc - done_cyc[i]),
                              (i == 0) ? 32'd1 : 32'(GAP1 + 1));
                        done_pending[i] = 1'b0;
                    end
                    empty = (i == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
                    if (empty) begin
                        check($sformatf("unexpected_start_%0d", i), 32'(uart_byte[i]), 32'hFFFF_FFFF);
                    end else begin
                        e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check($sformatf("byte_%0d", i), 32'(uart_byte[i]), 32'(e));
                    end
                end
                if (word_sent[i]) ws_cnt[i]++;
                if (m_done[i]) begin
                    done_pending[i] = 1'b1;
                    done_cyc[i]     = cyc;
                end
                if (idle[i]) done_pending[i] = 1'b0;
            end
        end
    end

    // Driver tasks
    task automatic send_word(input int i, input logic [31:0] w);
        int t;
        tx_float[i] = w;
        tx_valid[i] = 1'b1;
        t = 0;
        @(negedge clk);
        while (!tx_ready[i] && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("accept_ready", 32'(tx_ready[i]), 32'd1);
        @(posedge clk);
        #1;
        tx_valid[i] = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (i == 0) exp_q0.push_back(w[8*b +: 8]);
            else        exp_q1.push_back(w[8*b +: 8]);
        end
    endtask

    task automatic wait_idle(input int i);
        int   t;
        logic done;
        t = 0;
        done = 1'b0;
        while (!done && t < 500) begin
            @(negedge clk);
            done = idle[i] && !m_busy[i] &&
                   ((i == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0));
            t++;
        end
        check($sformatf("wait_idle_%0d", i), 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int w0;
        int t;
        n_checks = 0; n_fail = 0; cyc = 0;
        hold_busy = 1'b0; inj_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tx_float[i] = '0; tx_valid[i] = 1'b0;
            m_busy[i] = 1'b0; m_done[i] = 1'b0; m_cnt[i] = 0;
            start_seen[i] = 1'b0; st_cnt[i] = 0; ws_cnt[i] = 0;
            done_cyc[i] = 0; done_pending[i] = 1'b0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_tx_ready", 32'(tx_ready[i]), 32'd1);
            check("rst_uart_byte", 32'(uart_byte[i]), 32'd0);
            check("rst_uart_start", 32'(uart_start[i]), 32'd0);
            check("rst_word_sent", 32'(word_sent[i]), 32'd0);
            check("rst_idle", 32'(idle[i]), 32'd1);
        end
        @(posedge clk); #1;

        // Test 1: single word into an idle buffer
        send_word(0, 32'h3F80_0000);
        wait_idle(0);
        check("t1_starts", 32'(st_cnt[0]), 32'd4);
        check("t1_word_sent", 32'(ws_cnt[0]), 32'd1);
        check("t1_idle", 32'(idle[0]), 32'd1);

        // Test 2: back-to-back words with the second held pending
        send_word(0, 32'h3F80_0000);
        send_word(0, 32'h4049_0FDB);
        check("t2_ready_low", 32'(tx_ready[0]), 32'd0);
        wait_idle(0);
        check("t2_starts", 32'(st_cnt[0]), 32'd12);
        check("t2_word_sent", 32'(ws_cnt[0]), 32'd3);

        // Test 3: UART busy for 10 cycles after acceptance
        hold_busy = 1'b1;
        send_word(0, 32'h3F80_0000);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t3_start_held", 32'(uart_start[0]), 32'd0);
            check("t3_byte_stable", 32'(uart_byte[0]), 32'h00);
        end
        @(posedge clk); #1;
        hold_busy = 1'b0;
        @(negedge clk);
        check("t3_start_on_release", 32'(uart_start[0]), 32'd1);
        wait_idle(0);
        check("t3_word_sent", 32'(ws_cnt[0]), 32'd4);

        // Test 4: gap instance
        send_word(1, 32'h1122_3344);
        wait_idle(1);
        check("t4_starts", 32'(st_cnt[1]), 32'd4);
        check("t4_word_sent", 32'(ws_cnt[1]), 32'd1);
        check("t4_state_idle", 32'(fsm_state[1]), 32'd0);

        // Test 5: reset in mid-word while a word is pending
        s0 = st_cnt[0];
        send_word(0, 32'hAABB_CCDD);
        send_word(0, 32'h5566_7788);
        t = 0;
        while (st_cnt[0] < s0 + 2 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("t5_two_bytes", 32'(st_cnt[0]), 32'(s0 + 2));
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t5_pending_full", 32'(tx_ready[0]), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        exp_q0.delete();
        @(negedge clk);
        check("t5_rst_tx_ready", 32'(tx_ready[0]), 32'd1);
        check("t5_rst_byte", 32'(uart_byte[0]), 32'd0);
        check("t5_rst_start", 32'(uart_start[0]), 32'd0);
        check("t5_rst_word_sent", 32'(word_sent[0]), 32'd0);
        check("t5_rst_idle", 32'(idle[0]), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        s0 = st_cnt[0];
        w0 = ws_cnt[0];
        repeat (20) @(negedge clk);
        @(posedge clk); #1;
        check("t5_no_start", 32'(st_cnt[0]), 32'(s0));
        check("t5_no_word_sent", 32'(ws_cnt[0]), 32'(w0));
        send_word(0, 32'h0102_0304);
        wait_idle(0);
        check("t5_after_starts", 32'(st_cnt[0]), 32'(s0 + 4));
        check("t5_after_word_sent", 32'(ws_cnt[0]), 32'(w0 + 1));

        // Test 6: stray uart_done in IDLE and in the uart_start cycle
        inj_done = 1'b1;
        @(posedge clk); #1;
        inj_done = 1'b0;
        @(negedge clk);
        check("t6_idle_kept", 32'(idle[0]), 32'd1);
        check("t6_state_idle", 32'(fsm_state[0]), 32'd0);
        check("t6_no_start", 32'(uart_start[0]), 32'd0);
        @(posedge clk); #1;
        s0 = st_cnt[0];
        w0 = ws_cnt[0];
        send_word(0, 32'hDEAD_BEEF);
        inj_done = 1'b1;
        @(negedge clk);
        check("t6_start_cycle", 32'(uart_start[0]), 32'd1);
        @(posedge clk); #1;
        inj_done = 1'b0;
        wait_idle(0);
        check("t6_starts", 32'(st_cnt[0]), 32'(s0 + 4));
        check("t6_word_sent", 32'(ws_cnt[0]), 32'(w0 + 1));

        check("q0_drained", 32'(exp_q0.size()), 32'd0);
        check("q1_drained", 32'(exp_q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
